spypath_chain_meter: RTL and testbench
======================================

SPYPATH_CHAIN_METER -- requirements
Module: spypath_chain_meter

Interface
REQ-001 Parameter CHAIN_LEN, default 10: number of chained spypath_3_1 stages (range 2..256).
REQ-002 Parameter SAMPLE_WAIT, default 1: clk cycles between launch edge and tap capture (range 1..255).
REQ-003 Parameter ACC_SAMPLES, default 16: measurements accumulated per run (power of two, 1..1024).
REQ-004 Derived: DW = $clog2(CHAIN_LEN+1); AW = DW + $clog2(ACC_SAMPLES).
REQ-005 clk  input  1  single clock; all registers on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request one run; sampled only in IDLE.
REQ-008 cont  input  1  continuous mode; sampled at run completion.
REQ-009 busy  output  1  high while FSM not in IDLE.
REQ-010 done  output  1  one-cycle pulse at run completion.
REQ-011 depth  output  DW  propagation depth of most recent measurement.
REQ-012 acc  output  AW  sum of depths for last completed run; held until next done.

Function
REQ-013 Chain: CHAIN_LEN spypath_3_1 instances in series, each with controls 0,0,1,0 (inverting); stage 0 input = launch register; every stage output is a keep-attributed tap.
REQ-014 FSM states: IDLE, LAUNCH, WAIT, CAPTURE, DECODE, DONE.
REQ-015 IDLE -> LAUNCH when start=1; start in any other state is ignored, never queued.
REQ-016 LAUNCH (1 cycle): launch register toggles; wait counter loads SAMPLE_WAIT-1.
REQ-017 WAIT: counter decrements each cycle; -> CAPTURE in the cycle it reads 0.
REQ-018 CAPTURE (1 cycle): all CHAIN_LEN taps registered into snapshot register in one clock edge.
REQ-019 DECODE (1 cycle): expected tap i = L XOR (i even), L = new launch level; depth = count of consecutive matching taps from tap 0, stopping at first mismatch (0..CHAIN_LEN); depth register updates; running sum += depth.
REQ-020 DECODE -> LAUNCH if sample counter < ACC_SAMPLES-1 (counter increments), else -> DONE.
REQ-021 DONE (1 cycle): acc <= running sum, done=1; running sum and sample counter clear; -> LAUNCH if cont=1, else IDLE.
REQ-022 Per-measurement latency: SAMPLE_WAIT+3 cycles (LAUNCH, WAIT xSAMPLE_WAIT, CAPTURE, DECODE); run length ACC_SAMPLES*(SAMPLE_WAIT+3)+1 cycles start-to-done.
REQ-023 Sum width AW never overflows (max CHAIN_LEN*ACC_SAMPLES); no saturation logic.
REQ-024 Launch level alternates across measurements; decode always uses current level, so rising and falling edges both measure correctly.
REQ-025 cont deasserted mid-run takes effect only at DONE; current run completes.
REQ-026 busy=1 from cycle after start accepted through DONE cycle inclusive; busy=0 in IDLE only.

Reset
REQ-027 rst=1 forces asynchronously: FSM IDLE, launch register 0, snapshot 0, counters 0, running sum 0, depth 0, acc 0, busy 0, done 0.
REQ-028 rst mid-run aborts without a done pulse; first start after rst release begins a fresh run with launch level rising (0->1).

Verification
REQ-029 Reset: assert rst for 3 cycles mid-WAIT -> busy=0, done=0, depth=0, acc=0 within the same cycle; no done afterwards without start.
REQ-030 Single run, defaults, zero-delay chain model: pulse start -> done exactly 65 cycles later (16*4+1), depth=10, acc=160, busy drops the cycle after done.
REQ-031 Blocked propagation: bench forces tap 3 to its pre-launch value for every sample -> depth=3 each measurement, acc=48.
REQ-032 Start while busy: pulse start at cycles 5 and 30 of a run -> exactly one done; second run not started.
REQ-033 Continuous: cont=1 held -> done pulses every 65 cycles, acc=160 each; drop cont mid-run -> that run completes, one final done, return to IDLE.
REQ-034 Edge polarity: CHAIN_LEN=9, ACC_SAMPLES=1, zero-delay model -> two consecutive runs both report depth=9, launch level 1 then 0.

Source files
------------

// File: rtl/spypath_chain_meter.sv
// Delay-chain propagation meter.
// A launch register drives a chain of inverting spypath_3_1 cells. Each
// measurement toggles the launch level, waits SAMPLE_WAIT cycles and snapshots
// every tap. It then counts how many leading taps already show the new level.
// Depths are summed over ACC_SAMPLES measurements per run.

module spypath_3_1 (
  input  logic i_a,
  input  logic i_c0,
  input  logic i_c1,
  input  logic i_c2,
  input  logic i_c3,
  output logic o_y
);
  logic w_path;

  // Path select: c2 inverts the data path, c3 blocks it, c0 forces the constant c1.
  assign w_path = i_c2 ? ~i_a : i_a;
  assign o_y    = i_c0 ? i_c1 : (i_c3 ? 1'b0 : w_path);
endmodule

module spypath_chain_meter #(
  parameter  int CHAIN_LEN   = 10,
  parameter  int SAMPLE_WAIT = 1,
  parameter  int ACC_SAMPLES = 16,
  localparam int DW          = $clog2(CHAIN_LEN + 1),
  localparam int AW          = DW + $clog2(ACC_SAMPLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_cont,
  output logic          o_busy,
  output logic          o_done,
  output logic [DW-1:0] o_depth,
  output logic [AW-1:0] o_acc
);
  // Sample counter needs at least one bit, even when ACC_SAMPLES is 1.
  localparam int CW = (ACC_SAMPLES > 1) ? $clog2(ACC_SAMPLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_DECODE, S_DONE
  } state_t;

  state_t                 r_state, w_state_nx;
  logic                   r_launch;
  logic [7:0]             r_wait;
  logic [CW-1:0]          r_sample;
  logic [CHAIN_LEN-1:0]   r_snap;
  logic [DW-1:0]          r_depth;
  logic [AW-1:0]          r_sum;
  logic [AW-1:0]          r_acc;
  logic [CHAIN_LEN-1:0]   w_taps;
  logic [DW-1:0]          w_depth;
  logic                   w_hit;

  // The delay chain: each stage is an inverter cell. Every stage output is a kept tap.
  for (genvar i = 0; i < CHAIN_LEN; i++) begin : g_stage
    (* keep = "true" *) logic w_tap;
    logic w_in;
    if (i == 0) begin : g_head
      assign w_in = r_launch;
    end else begin : g_link
      assign w_in = g_stage[i-1].w_tap;
    end
    spypath_3_1 u_cell (
      .i_a  (w_in),
      .i_c0 (1'b0),
      .i_c1 (1'b0),
      .i_c2 (1'b1),
      .i_c3 (1'b0),
      .o_y  (w_tap)
    );
    assign w_taps[i] = w_tap;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state and status outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_state_nx = r_state;
    o_busy     = (r_state != S_IDLE);
    o_done     = 1'b0;
    case (r_state)
      S_IDLE:    if (i_start) w_state_nx = S_LAUNCH;
      S_LAUNCH:  w_state_nx = S_WAIT;
      S_WAIT:    if (r_wait == 8'd0) w_state_nx = S_CAPTURE;
      S_CAPTURE: w_state_nx = S_DECODE;
      S_DECODE:  w_state_nx = (r_sample == CW'(ACC_SAMPLES - 1)) ? S_DONE : S_LAUNCH;
      S_DONE: begin
        o_done     = 1'b1;
        w_state_nx = i_cont ? S_LAUNCH : S_IDLE;
      end
      default:   w_state_nx = S_IDLE;
    endcase
  end

  // Depth decode: leading taps that already match the current launch level.
  // Inverting stages alternate, so even taps expect ~L and odd taps expect L.
  always_comb begin
    w_depth = DW'(CHAIN_LEN);
    w_hit   = 1'b0;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      if (!w_hit && (r_snap[i] != (r_launch ^ ((i % 2) == 0)))) begin
        w_depth = DW'(i);
        w_hit   = 1'b1;
      end
    end
  end

  // Measurement datapath: launch, wait count, snapshot, accumulate, publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_launch <= 1'b0;
      r_wait   <= '0;
      r_sample <= '0;
      r_snap   <= '0;
      r_depth  <= '0;
      r_sum    <= '0;
      r_acc    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        S_LAUNCH: begin
          r_launch <= ~r_launch;
          r_wait   <= 8'(SAMPLE_WAIT - 1);
        end
        S_WAIT: if (r_wait != 8'd0) r_wait <= r_wait - 8'd1;
        S_CAPTURE: r_snap <= w_taps;
        S_DECODE: begin
          r_depth <= w_depth;
          r_sum   <= r_sum + AW'(w_depth);
          if (r_sample != CW'(ACC_SAMPLES - 1)) r_sample <= r_sample + CW'(1);
        end
        S_DONE: begin
          r_acc    <= r_sum;
          r_sum    <= '0;
          r_sample <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_depth = r_depth;
  assign o_acc   = r_acc;
endmodule

// File: tb/tb_spypath_chain_meter.sv
// Self-checking bench for spypath_chain_meter: vector table, corner sequences,
// and a randomized run against a run-position reference model.
module tb_spypath_chain_meter;
  localparam int CL   = 10;
  localparam int SW   = 1;
  localparam int AS   = 16;
  localparam int MEAS = SW + 3;      // cycles per measurement
  localparam int RUN  = AS * MEAS;   // cycles from LAUNCH of first sample to DONE
  localparam int FULL = CL * AS;

  logic       clk, rst, start, cont, start2, cont2;
  logic       busy, done, busy2, done2;
  logic [3:0] depth;
  logic [7:0] acc;
  logic [3:0] depth2;
  logic [3:0] acc2;

  int n_checks = 0;
  int n_fail   = 0;

  spypath_chain_meter dut (
    .clk(clk), .rst(rst), .i_start(start), .i_cont(cont),
    .o_busy(busy), .o_done(done), .o_depth(depth), .o_acc(acc)
  );

  spypath_chain_meter #(.CHAIN_LEN(9), .SAMPLE_WAIT(1), .ACC_SAMPLES(1)) dut2 (
    .clk(clk), .rst(rst), .i_start(start2), .i_cont(cont2),
    .o_busy(busy2), .o_done(done2), .o_depth(depth2), .o_acc(acc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int off2;      // cycle of a second start pulse (0 = none)
    int exp_cnt;   // done pulses expected in the window
    int exp_last;  // cycle of the last done pulse
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    int cnt   = 0;
    int first = -1;
    int last  = -1;
    for (int t = 0; t <= 140; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cnt++;
        if (first < 0) first = t;
        last = t;
      end
      if (t == RUN + 2) begin
        check("vec_busy_after_done", busy, 0);
        check("vec_acc", acc, FULL);
        check("vec_depth", depth, CL);
      end
      start = (t == 0) || (v.off2 != 0 && t == v.off2);
    end
    check("vec_done_count", cnt, v.exp_cnt);
    check("vec_first_done", first, RUN + 1);
    check("vec_last_done", last, v.exp_last);
  endtask

  // Reference model state: position within a run, independent of FSM encoding.
  bit m_idle;
  int m_pos;
  int m_acc;
  int m_depth;

  task automatic model_step(input logic r, input logic s, input logic c);
    if (r) begin
      m_idle = 1; m_pos = 0; m_acc = 0; m_depth = 0;
    end else if (m_idle) begin
      if (s) begin m_idle = 0; m_pos = 0; end
    end else if (m_pos == RUN) begin
      m_acc = FULL;
      if (c) m_pos = 0;
      else   m_idle = 1;
    end else begin
      if ((m_pos % MEAS) == MEAS - 1) m_depth = CL;
      m_pos++;
    end
  endtask

  initial begin
    int cnt;
    int dones[$];

    vecs[0] = '{off2: 0,  exp_cnt: 1, exp_last: RUN + 1};
    vecs[1] = '{off2: 5,  exp_cnt: 1, exp_last: RUN + 1};
    vecs[2] = '{off2: 30, exp_cnt: 1, exp_last: RUN + 1};
    vecs[3] = '{off2: 65, exp_cnt: 1, exp_last: RUN + 1};
    vecs[4] = '{off2: 66, exp_cnt: 2, exp_last: 66 + RUN + 1};

    rst = 1'b1; start = 1'b0; cont = 1'b0; start2 = 1'b0; cont2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_depth", depth, 0);
    check("reset_acc", acc, 0);
    rst = 1'b0;

    // Single runs and start pulses that land while busy.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of WAIT clears everything in the same cycle.
    for (int t = 0; t <= 2; t++) begin
      @(negedge clk);
      start = (t == 0);
    end
    check("midrun_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_depth", depth, 0);
    check("rst_acc", acc, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    check("rst_no_done", cnt, 0);
    check("rst_idle", busy, 0);

    // Blocked propagation: tap 3 held at its pre-launch level each sample.
    // After reset the pre-launch level for sample k is k%2.
    for (int t = 0; t <= RUN + 2; t++) begin
      @(negedge clk);
      if (t >= 5 && ((t - 5) % MEAS) == 0 && t <= RUN + 1)
        check("blocked_depth", depth, 3);
      if (t == RUN + 1) check("blocked_done", done, 1);
      if (t == RUN + 2) check("blocked_acc", acc, 3 * AS);
      if (t >= 1 && ((t - 1) % MEAS) == 0 && t <= RUN - 3) begin
        if ((((t - 1) / MEAS) % 2) == 1) force dut.g_stage[3].w_tap = 1'b1;
        else                             force dut.g_stage[3].w_tap = 1'b0;
      end
      start = (t == 0);
    end
    release dut.g_stage[3].w_tap;

    // Continuous mode; cont dropped during the third run.
    dones = {};
    for (int t = 0; t <= 270; t++) begin
      @(negedge clk);
      if (done === 1'b1) dones.push_back(t);
      if (t == RUN + 2 || t == 2 * (RUN + 1) + 1 || t == 3 * (RUN + 1) + 1)
        check("cont_acc", acc, FULL);
      if (t == 2 * (RUN + 1) + 1) check("cont_busy_between", busy, 1);
      if (t == 3 * (RUN + 1) + 1) check("cont_final_idle", busy, 0);
      if (t == 0)   begin start = 1'b1; cont = 1'b1; end
      else          start = 1'b0;
      if (t == 150) cont = 1'b0;
    end
    check("cont_done_count", dones.size(), 3);
    for (int k = 0; k < 3 && k < dones.size(); k++)
      check("cont_done_time", dones[k], (k + 1) * (RUN + 1));

    // Edge polarity: 9-stage chain, one sample per run, two runs back to back.
    for (int t = 0; t <= 12; t++) begin
      @(negedge clk);
      if (t == 5 || t == 11) check("pol_done", done2, 1);
      if (t == 6) begin
        check("pol_depth_rise", depth2, 9);
        check("pol_acc_rise", acc2, 9);
        check("pol_level_rise", dut2.r_launch, 1);
      end
      if (t == 12) begin
        check("pol_depth_fall", depth2, 9);
        check("pol_acc_fall", acc2, 9);
        check("pol_level_fall", dut2.r_launch, 0);
        check("pol_idle", busy2, 0);
      end
      start2 = (t == 0) || (t == 6);
    end

    // Randomized start/cont/reset against the run-position model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; cont = 1'b0;
    m_idle = 1; m_pos = 0; m_acc = 0; m_depth = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      check("rnd_busy", busy, !m_idle);
      check("rnd_done", done, (!m_idle && m_pos == RUN));
      check("rnd_acc", acc, m_acc);
      check("rnd_depth", depth, m_depth);
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) cont = ~cont;
      if (rst) #1;
      model_step(rst, start, cont);
    end
    rst = 1'b0; start = 1'b0; cont = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
